uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Message-level arbiter that shares the single UART transmit byte path between several byte-stream requesters. Example requesters: the gesture ASCII reporter and a status/telemetry generator. Once a requester is granted, it owns the transmitter until it sends a byte flagged last, so messages are never interleaved. A byte-count limit and a stall timeout prevent any requester from hanging the link. Sits between the message sources inside the gesture core and the UART TX serializer that drives `uart_tx`.

## Interface
- `NUM_REQ`, 2: number of requesters (2–4).
- `MAX_MSG_LEN`, 16: maximum bytes per granted message; the 16th byte is forced as last.
- `IDLE_TIMEOUT_CYC`, 1200: consecutive cycles the grantee may hold `req_valid` low mid-message before the grant is revoked.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_data`  in  NUM_REQ*8  byte per requester; requester i uses bits [8i+7:8i].
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_last`  in  NUM_REQ  byte is the final byte of the message.
- `req_ready`  out  NUM_REQ  byte accepted when `req_valid[i] && req_ready[i]`.
- `tx_data`  out  8  byte to the UART TX serializer.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  serializer accepts `tx_data` this cycle.
- `grant_id`  out  $clog2(NUM_REQ)  current/most recent grantee.
- `busy`  out  1  a message is in progress (state XFER).
- `abort_pulse`  out  1  one-cycle pulse on forced release.
- `abort_count`  out  8  saturating count of forced releases.

## Operation
- States: IDLE, XFER.
- IDLE:
  - If any `req_valid` is high, select a winner and register it in `grant_id`.
  - Clear the byte and stall counters, then go to XFER.
  - If no request is valid, stay in IDLE.
- Selection: fixed priority with index 0 highest, unless round-robin is compiled in (see Configuration).
- XFER byte acceptance:
  - `req_ready[g] = (!tx_valid || tx_ready)` for the grantee g.
  - `req_ready` is 0 for all non-grantees.
  - An accepted byte loads the output register: `tx_data <= byte` and `tx_valid <= 1`.
  - `tx_valid` clears when `tx_ready` is high and no new byte is loaded in the same cycle.
- Byte counter:
  - Width `$clog2(MAX_MSG_LEN+1)`; increments on each accepted byte.
  - When the accepted byte has `req_last[g]` set, go to IDLE.
  - If the count reaches `MAX_MSG_LEN` without `req_last`, treat that byte as last, pulse `abort_pulse`, increment `abort_count`, and go to IDLE.
- Stall counter:
  - Increments each XFER cycle in which `req_valid[g]` is 0.
  - Clears whenever `req_valid[g]` is 1.
  - When it reaches `IDLE_TIMEOUT_CYC`, pulse `abort_pulse`, increment `abort_count`, and go to IDLE.
  - A byte already in the output register is still delivered.
- `abort_count` saturates at 255. Both abort causes firing in the same cycle count once.
- `busy` is 1 exactly in XFER. `grant_id` holds its value through IDLE until the next grant.

## Timing
- Reset values:
  - `tx_valid`, `tx_data`, `req_ready`, `grant_id`, `busy`, `abort_pulse`, `abort_count` are all 0.
  - Round-robin pointer is 0; state is IDLE.
- Reset mid-message discards the output-register byte: `tx_valid` is low in the first cycle after `rst`.
- Grant latency:
  - `req_valid` seen in IDLE at cycle T → `busy` and `req_ready` high at T+1 (output register free).
  - First byte on `tx_data` at T+2.
- Byte latency: a byte accepted at cycle N is on `tx_data`/`tx_valid` at N+1.
- Output stability: `tx_data` is stable while `tx_valid && !tx_ready`.
- Throughput: one byte per cycle when `tx_ready` is held high.
- Every message boundary inserts exactly one IDLE arbitration cycle, even when another requester is waiting.
- Requests that arrive while a message is in progress wait; they are not dropped.
- Requester-side rule: `req_valid`, `req_data`, `req_last` must hold until accepted. The arbiter does not check this.

## Configuration
- `UART_ARB_RR_EN` defined:
  - Round-robin selection: the search starts at index `(last grantee + 1) mod NUM_REQ`.
  - The pointer updates on every grant.
- `UART_ARB_RR_EN` undefined: fixed priority with index 0 highest; no pointer register.

## Test plan
- Single requester:
  - Stimulus: requester 0 sends 'U','P','\n' (0x55 0x50 0x0A) with last on 0x0A, `tx_ready`=1.
  - Response: `tx_data` shows 0x55, 0x50, 0x0A on consecutive cycles starting 2 cycles after `req_valid`; `busy` falls after the last byte.
- No interleave:
  - Stimulus: requester 1 mid-4-byte message; requester 0 raises valid.
  - Response: all 4 bytes of requester 1 are contiguous; requester 0 is granted after one IDLE cycle.
- Priority vs round-robin:
  - Stimulus: both requesters continuously send 1-byte messages.
  - Response, fixed priority: only `grant_id`=0 is served.
  - Response, with `UART_ARB_RR_EN`: `grant_id` alternates 0,1,0,1.
- Length abort:
  - Stimulus: requester sends 20 bytes without last, `MAX_MSG_LEN`=16.
  - Response: 16 bytes forwarded, one `abort_pulse`, `abort_count`=1, `busy`=0.
- Stall abort and backpressure:
  - Stimulus: grantee drops valid for 1200 cycles; separately, `tx_ready` is held low for 50 cycles.
  - Response, stall: abort at cycle 1200.
  - Response, backpressure: `tx_data` stays constant and `req_ready`=0 throughout.
- Reset mid-message:
  - Stimulus: assert `rst` for one cycle during byte 2.
  - Response: all outputs at reset values on the next cycle; no residual `tx_valid`.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Message-level arbiter sharing one UART TX byte path between
//            NUM_REQ byte-stream requesters. A grantee owns the transmitter
//            until its last byte, a length limit or a stall timeout.
// Options  : UART_ARB_RR_EN - round-robin selection instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int MAX_MSG_LEN      = 16,
    parameter int IDLE_TIMEOUT_CYC = 1200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       abort_pulse,
    output logic [7:0]                 abort_count
);

    localparam int c_GW = $clog2(NUM_REQ);
    localparam int c_BW = $clog2(MAX_MSG_LEN + 1);
    localparam int c_SW = $clog2(IDLE_TIMEOUT_CYC + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_XFER = 1'b1;

    logic [0:0]      r_state;
    logic [c_GW-1:0] r_grant;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
    logic            r_abort;
    logic [7:0]      r_abort_cnt;
    logic [c_BW-1:0] r_byte_cnt;
    logic [c_SW-1:0] r_stall;

    logic            w_any_req;
    logic [c_GW-1:0] w_winner;
    logic            w_g_valid;
    logic            w_g_last;
    logic [7:0]      w_g_data;
    logic            w_room;
    logic            w_accept;
    logic [c_BW-1:0] w_byte_next;
    logic            w_len_hit;
    logic            w_stall_hit;
    logic            w_abort;

    assign w_any_req   = |req_valid;
    assign w_g_valid   = req_valid[r_grant];
    assign w_g_last    = req_last[r_grant];
    assign w_g_data    = req_data[{r_grant, 3'b000} +: 8];
    assign w_room      = !r_tx_valid || tx_ready;
    assign w_accept    = (r_state == c_XFER) && w_g_valid && w_room;
    assign w_byte_next = r_byte_cnt + 1'b1;

    // The byte that fills the message budget is forced to be the last one.
    assign w_len_hit   = w_accept && !w_g_last && (w_byte_next == c_BW'(MAX_MSG_LEN));
    assign w_stall_hit = (r_state == c_XFER) && !w_g_valid
                         && (r_stall == c_SW'(IDLE_TIMEOUT_CYC - 1));
    assign w_abort     = w_len_hit || w_stall_hit;

`ifdef UART_ARB_RR_EN
    logic [c_GW-1:0] r_ptr;
    logic [c_GW-1:0] w_idx;
    logic            w_found;

    // Search starts just after the previous grantee, wrapping at NUM_REQ.
    always_comb begin
        w_winner = r_ptr;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = c_GW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_winner = c_GW'(k);
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        if (r_state == c_XFER) begin
            req_ready[r_grant] = w_room;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_grant     <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_abort     <= 1'b0;
            r_abort_cnt <= '0;
            r_byte_cnt  <= '0;
            r_stall     <= '0;
`ifdef UART_ARB_RR_EN
            r_ptr       <= '0;
`endif
        end else begin
            r_abort <= 1'b0;

            // Output register drains independently of the arbitration state.
            if (w_accept) begin
                r_tx_data  <= w_g_data;
                r_tx_valid <= 1'b1;
            end else if (tx_ready) begin
                r_tx_valid <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= w_winner;
                        r_byte_cnt <= '0;
                        r_stall    <= '0;
                        r_state    <= c_XFER;
`ifdef UART_ARB_RR_EN
                        r_ptr      <= (w_winner == c_GW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
`endif
                    end
                end
                c_XFER: begin
                    if (w_g_valid) begin
                        r_stall <= '0;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
                    if (w_accept) begin
                        r_byte_cnt <= w_byte_next;
                    end
                    if ((w_accept && w_g_last) || w_abort) begin
                        r_state <= c_IDLE;
                    end
                    if (w_abort) begin
                        r_abort <= 1'b1;
                        if (r_abort_cnt != 8'hFF) begin
                            r_abort_cnt <= r_abort_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign grant_id    = r_grant;
    assign busy        = (r_state == c_XFER);
    assign abort_pulse = r_abort;
    assign abort_count = r_abort_cnt;

endmodule
`default_nettype wire
